// File: rtl/exe_wb_queue_pkg.sv
// ============================================================================
// exe_wb_queue_pkg
// Shared execution-unit / exception types used by the buffered writeback
// controller: register index, exception codes and the queued writeback entry.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package exe_wb_queue_pkg;

    localparam int DataWidth = 32;

    // Architectural register index
    typedef logic [4:0] RegFile_t;

    // Exception cause codes; EXP_I_MISS_ALIGN doubles as the idle value
    typedef enum logic [3:0] {
        EXP_I_MISS_ALIGN = 4'd0,
        EXP_I_ACC_FAULT  = 4'd1,
        EXP_ILLEGAL      = 4'd2,
        EXP_BREAK        = 4'd3,
        EXP_L_MISS_ALIGN = 4'd4,
        EXP_L_ACC_FAULT  = 4'd5,
        EXP_S_MISS_ALIGN = 4'd6,
        EXP_S_ACC_FAULT  = 4'd7,
        EXP_ECALL        = 4'd8
    } ExpCode_t;

    // One completed result waiting for (or holding) a writeback slot
    typedef struct packed {
        RegFile_t               rd;
        logic                   exp_;
        ExpCode_t               exp_code;
        logic [DataWidth-1:0]   res;
        logic                   pred_miss_;
        logic                   jump_miss_;
    } WbEntry_t;

endpackage

`default_nettype wire

// File: rtl/exe_wb_queue_fifo.sv
// ============================================================================
// wb_fifo
// Parametrised synchronous FIFO with synchronous clear.
//   clk, reset_   : clock, asynchronous active-low reset
//   clr_i         : drop all contents (pointers and count to zero)
//   push_i/din_i  : write at tail (ignored when full)
//   pop_i         : advance head (ignored when empty)
//   head_o        : oldest entry, count_o : occupancy, full_o/empty_o
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_,
    input  logic                         clr_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             din_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rptr_q];

    // Guarded here as well so the count can never leave 0..DEPTH
    assign w_push = push_i && !full_o && !clr_i;
    assign w_pop  = pop_i && !empty_o && !clr_i;

    // Pointers are exactly log2(DEPTH) bits so they wrap for free
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (clr_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (w_push) wptr_q <= wptr_q + AW'(1);
            if (w_pop)  rptr_q <= rptr_q + AW'(1);
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; only slots between the pointers are ever read out
    always_ff @(posedge clk) begin
        if (w_push) mem_q[wptr_q] <= din_i;
    end

endmodule

`default_nettype wire

// File: rtl/exe_wb_queue.sv
// ============================================================================
// exe_wb_queue
// Buffered writeback controller for a single-cycle execution unit. Queues up
// to DEPTH results in order, optionally bypasses an issue straight to the
// writeback arbiter when the queue is empty, and registers the granted entry
// onto the wb_* payload for exactly one cycle (wb_e_ low).
//   Inputs : clk, reset_, flush_, issue_e_, rd, exp_, exp_code, res,
//            pred_miss_, jump_miss_, wb_ack_
//   Outputs: wb_req_, pre_wb_rd (combinational), wb_e_ and wb_* payload
//            (registered), busy (queue full), count (occupancy)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module exe_wb_queue
    import exe_wb_queue_pkg::*;
#(
    parameter int DATA   = DataWidth,
    parameter int DEPTH  = 4,
    parameter bit BYPASS = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset_,
    input  logic                         flush_,
    input  logic                         issue_e_,
    input  RegFile_t                     rd,
    input  logic                         exp_,
    input  ExpCode_t                     exp_code,
    input  logic [DATA-1:0]              res,
    input  logic                         pred_miss_,
    input  logic                         jump_miss_,
    input  logic                         wb_ack_,
    output logic                         wb_req_,
    output RegFile_t                     pre_wb_rd,
    output logic                         wb_e_,
    output RegFile_t                     wb_rd,
    output logic [DATA-1:0]              wb_data,
    output logic                         wb_exp_,
    output ExpCode_t                     wb_exp_code,
    output logic                         wb_pred_miss_,
    output logic                         wb_jump_miss_,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int EW = $bits(WbEntry_t);

    WbEntry_t        in_entry;
    WbEntry_t        head_entry;
    WbEntry_t        sel_entry;
    WbEntry_t        wb_d;
    WbEntry_t        wb_q;
    logic            wb_e_d;
    logic            wb_e_q;
    logic [EW-1:0]   head_vec;
    logic            fifo_empty;
    logic            fifo_full;
    logic            bypass_ok;
    logic            req;
    logic            grant;
    logic            push;
    logic            pop;

    always_comb begin
        in_entry            = '0;
        in_entry.rd         = rd;
        in_entry.exp_       = exp_;
        in_entry.exp_code   = exp_code;
        in_entry.res        = DataWidth'(res);
        in_entry.pred_miss_ = pred_miss_;
        in_entry.jump_miss_ = jump_miss_;
    end

    assign head_entry = WbEntry_t'(head_vec);

    // Request from the head whenever anything is queued; with bypass enabled an
    // issue into an empty queue may request in its own cycle. Flush masks all.
    assign bypass_ok = BYPASS && fifo_empty && !issue_e_;
    assign req       = flush_ && (!fifo_empty || bypass_ok);
    assign grant     = req && !wb_ack_;
    assign wb_req_   = !req;
    assign pre_wb_rd = fifo_empty ? rd : head_entry.rd;
    assign sel_entry = fifo_empty ? in_entry : head_entry;

    // A bypassed issue granted on the spot never touches the queue
    assign push = flush_ && !issue_e_ && !fifo_full && !(bypass_ok && grant);
    assign pop  = grant && !fifo_empty;

    wb_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_  (reset_),
        .clr_i   (!flush_),
        .push_i  (push),
        .din_i   (in_entry),
        .pop_i   (pop),
        .head_o  (head_vec),
        .count_o (count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Payload holds its last value between grants; only wb_e_ pulses
    always_comb begin
        wb_d   = wb_q;
        wb_e_d = 1'b1;
        if (grant) begin
            wb_d   = sel_entry;
            wb_e_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wb_e_q          <= 1'b1;
            wb_q.rd         <= '0;
            wb_q.exp_       <= 1'b1;
            wb_q.exp_code   <= EXP_I_MISS_ALIGN;
            wb_q.res        <= '0;
            wb_q.pred_miss_ <= 1'b1;
            wb_q.jump_miss_ <= 1'b1;
        end else begin
            wb_e_q <= wb_e_d;
            wb_q   <= wb_d;
        end
    end

    assign wb_e_          = wb_e_q;
    assign wb_rd          = wb_q.rd;
    assign wb_data        = DATA'(wb_q.res);
    assign wb_exp_        = wb_q.exp_;
    assign wb_exp_code    = wb_q.exp_code;
    assign wb_pred_miss_  = wb_q.pred_miss_;
    assign wb_jump_miss_  = wb_q.jump_miss_;
    assign busy           = fifo_full;

    // Issuing into a full queue loses the result
    a_no_issue_when_busy: assert property (
        @(posedge clk) disable iff (!reset_) !(flush_ && !issue_e_ && fifo_full)
    );

endmodule

`default_nettype wire

// File: tb/tb_exe_wb_queue.sv
// ============================================================================
// tb_exe_wb_queue
// Directed self-checking bench for exe_wb_queue (DEPTH=4, BYPASS=1).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exe_wb_queue;
    import exe_wb_queue_pkg::*;

    localparam int DEPTH = 4;

    logic           clk;
    logic           reset_;
    logic           flush_;
    logic           issue_e_;
    RegFile_t       rd;
    logic           exp_;
    ExpCode_t       exp_code;
    logic [31:0]    res;
    logic           pred_miss_;
    logic           jump_miss_;
    logic           wb_ack_;
    logic           wb_req_;
    RegFile_t       pre_wb_rd;
    logic           wb_e_;
    RegFile_t       wb_rd;
    logic [31:0]    wb_data;
    logic           wb_exp_;
    ExpCode_t       wb_exp_code;
    logic           wb_pred_miss_;
    logic           wb_jump_miss_;
    logic           busy;
    logic [2:0]     count;

    int n_cmp  = 0;
    int n_fail = 0;

    exe_wb_queue #(.DATA(32), .DEPTH(DEPTH), .BYPASS(1'b1)) dut (
        .clk           (clk),
        .reset_        (reset_),
        .flush_        (flush_),
        .issue_e_      (issue_e_),
        .rd            (rd),
        .exp_          (exp_),
        .exp_code      (exp_code),
        .res           (res),
        .pred_miss_    (pred_miss_),
        .jump_miss_    (jump_miss_),
        .wb_ack_       (wb_ack_),
        .wb_req_       (wb_req_),
        .pre_wb_rd     (pre_wb_rd),
        .wb_e_         (wb_e_),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .wb_exp_       (wb_exp_),
        .wb_exp_code   (wb_exp_code),
        .wb_pred_miss_ (wb_pred_miss_),
        .wb_jump_miss_ (wb_jump_miss_),
        .busy          (busy),
        .count         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush_     = 1'b1;
        issue_e_   = 1'b1;
        wb_ack_    = 1'b1;
        rd         = '0;
        exp_       = 1'b1;
        exp_code   = EXP_I_MISS_ALIGN;
        res        = '0;
        pred_miss_ = 1'b1;
        jump_miss_ = 1'b1;
    endtask

    task automatic issue(input int r, input logic [31:0] d);
        issue_e_ = 1'b0;
        rd       = RegFile_t'(r);
        res      = d;
    endtask

    task automatic test_reset();
        reset_ = 1'b0;
        idle();
        repeat (2) tick();
        reset_ = 1'b1;
        tick();
        n_cmp++; if (wb_e_ !== 1'b1) begin n_fail++; $display("FAIL reset_wb_e_: got %0b expected 1", wb_e_); end
        n_cmp++; if (wb_req_ !== 1'b1) begin n_fail++; $display("FAIL reset_wb_req_: got %0b expected 1", wb_req_); end
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_cmp++; if (wb_rd !== 5'd0) begin n_fail++; $display("FAIL reset_wb_rd: got %0d expected 0", wb_rd); end
        n_cmp++; if (wb_data !== 32'd0) begin n_fail++; $display("FAIL reset_wb_data: got %0h expected 0", wb_data); end
        n_cmp++; if (wb_exp_code !== EXP_I_MISS_ALIGN) begin n_fail++; $display("FAIL reset_wb_exp_code: got %0d expected 0", wb_exp_code); end
        n_cmp++; if ({wb_exp_, wb_pred_miss_, wb_jump_miss_} !== 3'b111) begin n_fail++; $display("FAIL reset_wb_flags: got %b expected 111", {wb_exp_, wb_pred_miss_, wb_jump_miss_}); end
    endtask

    task automatic test_bypass();
        issue(5, 32'hA5);
        wb_ack_ = 1'b0;
        #1;
        n_cmp++; if (wb_req_ !== 1'b0) begin n_fail++; $display("FAIL byp_wb_req_: got %0b expected 0", wb_req_); end
        n_cmp++; if (pre_wb_rd !== 5'd5) begin n_fail++; $display("FAIL byp_pre_wb_rd: got %0d expected 5", pre_wb_rd); end
        tick();
        idle();
        n_cmp++; if (wb_e_ !== 1'b0) begin n_fail++; $display("FAIL byp_wb_e_: got %0b expected 0", wb_e_); end
        n_cmp++; if (wb_rd !== 5'd5 || wb_data !== 32'hA5) begin n_fail++; $display("FAIL byp_payload: got rd %0d data %0h expected rd 5 data a5", wb_rd, wb_data); end
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL byp_count: got %0d expected 0", count); end
        tick();
        n_cmp++; if (wb_e_ !== 1'b1) begin n_fail++; $display("FAIL byp_one_cycle: got %0b expected 1", wb_e_); end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 4; i++) begin
            issue(i, 32'h100 + 32'(i));
            tick();
        end
        idle();
        #1;
        n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d expected 4", count); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fill_busy: got %0b expected 1", busy); end
        n_cmp++; if (pre_wb_rd !== 5'd1) begin n_fail++; $display("FAIL fill_pre_wb_rd: got %0d expected 1", pre_wb_rd); end
        n_cmp++; if (wb_e_ !== 1'b1) begin n_fail++; $display("FAIL fill_no_wb: got %0b expected 1", wb_e_); end
        for (int i = 1; i <= 4; i++) begin
            wb_ack_ = 1'b0;
            tick();
            n_cmp++;
            if (wb_e_ !== 1'b0 || wb_rd !== RegFile_t'(i) || wb_data !== 32'h100 + 32'(i)) begin
                n_fail++;
                $display("FAIL drain_%0d: got e %0b rd %0d data %0h expected e 0 rd %0d data %0h",
                         i, wb_e_, wb_rd, wb_data, i, 32'h100 + 32'(i));
            end
        end
        wb_ack_ = 1'b1;
        n_cmp++; if (count !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL drain_count: got %0d/%0b expected 0/0", count, busy); end
        tick();
        n_cmp++; if (wb_e_ !== 1'b1) begin n_fail++; $display("FAIL drain_end: got %0b expected 1", wb_e_); end
    endtask

    task automatic test_push_pop();
        issue(6, 32'h66); tick();
        issue(7, 32'h77); tick();
        idle();
        n_cmp++; if (count !== 3'd2) begin n_fail++; $display("FAIL pp_count_pre: got %0d expected 2", count); end
        issue(8, 32'h88);
        wb_ack_ = 1'b0;
        tick();
        idle();
        n_cmp++; if (wb_e_ !== 1'b0 || wb_rd !== 5'd6) begin n_fail++; $display("FAIL pp_head: got e %0b rd %0d expected e 0 rd 6", wb_e_, wb_rd); end
        n_cmp++; if (count !== 3'd2) begin n_fail++; $display("FAIL pp_count: got %0d expected 2", count); end
        wb_ack_ = 1'b0;
        tick();
        n_cmp++; if (wb_e_ !== 1'b0 || wb_rd !== 5'd7) begin n_fail++; $display("FAIL pp_second: got e %0b rd %0d expected e 0 rd 7", wb_e_, wb_rd); end
        tick();
        n_cmp++; if (wb_rd !== 5'd8 || wb_data !== 32'h88) begin n_fail++; $display("FAIL pp_tail: got rd %0d data %0h expected rd 8 data 88", wb_rd, wb_data); end
        wb_ack_ = 1'b1;
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL pp_count_end: got %0d expected 0", count); end
        tick();
    endtask

    task automatic test_flush();
        for (int i = 9; i <= 12; i++) begin
            issue(i, 32'h90 + 32'(i));
            exp_ = 1'b0;
            exp_code = EXP_I_MISS_ALIGN;
            tick();
        end
        idle();
        wb_ack_ = 1'b0;
        tick();
        idle();
        n_cmp++; if (wb_e_ !== 1'b0 || wb_rd !== 5'd9 || wb_exp_ !== 1'b0) begin n_fail++; $display("FAIL fl_pre_grant: got e %0b rd %0d exp %0b expected e 0 rd 9 exp 0", wb_e_, wb_rd, wb_exp_); end
        n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL fl_pre_count: got %0d expected 3", count); end
        flush_ = 1'b0;
        issue(13, 32'hDD);
        wb_ack_ = 1'b0;
        #1;
        n_cmp++; if (wb_req_ !== 1'b1) begin n_fail++; $display("FAIL fl_req_mask: got %0b expected 1", wb_req_); end
        tick();
        idle();
        n_cmp++; if (count !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL fl_count: got %0d/%0b expected 0/0", count, busy); end
        n_cmp++; if (wb_e_ !== 1'b1) begin n_fail++; $display("FAIL fl_wb_e_: got %0b expected 1", wb_e_); end
        n_cmp++; if (wb_req_ !== 1'b1) begin n_fail++; $display("FAIL fl_wb_req_: got %0b expected 1", wb_req_); end
        wb_ack_ = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (wb_e_ !== 1'b1 || wb_rd !== 5'd9) begin n_fail++; $display("FAIL fl_residual_%0d: got e %0b rd %0d expected e 1 rd 9", i, wb_e_, wb_rd); end
        end
        idle();
        tick();
    endtask

    task automatic test_async_reset();
        issue(3, 32'h33); tick();
        issue(4, 32'h44); tick();
        idle();
        n_cmp++; if (count !== 3'd2) begin n_fail++; $display("FAIL ar_pre_count: got %0d expected 2", count); end
        #2;
        reset_ = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd0 || wb_req_ !== 1'b1) begin n_fail++; $display("FAIL ar_clear: got count %0d req %0b expected 0/1", count, wb_req_); end
        n_cmp++; if (wb_rd !== 5'd0) begin n_fail++; $display("FAIL ar_wb_rd: got %0d expected 0", wb_rd); end
        tick();
        reset_ = 1'b1;
        tick();
        n_cmp++; if (wb_e_ !== 1'b1 || count !== 3'd0) begin n_fail++; $display("FAIL ar_after: got e %0b count %0d expected 1/0", wb_e_, count); end
    endtask

    task automatic test_wrap();
        logic [37:0] expq [$];
        logic [37:0] e;
        logic        pm;
        int          issued = 0;
        int          got    = 0;
        int          cyc    = 0;
        while (got < 3*DEPTH && cyc < 500) begin
            idle();
            if (issued < 3*DEPTH && !busy && $urandom_range(0, 3) != 0) begin
                pm = 1'($urandom_range(0, 1));
                issue(issued + 16, $urandom);
                pred_miss_ = pm;
                expq.push_back({pm, rd, res});
                issued++;
            end
            if (issued == 3*DEPTH || $urandom_range(0, 2) == 0) wb_ack_ = 1'b0;
            tick();
            cyc++;
            if (wb_e_ === 1'b0) begin
                n_cmp++;
                if (expq.size() == 0) begin
                    n_fail++;
                    $display("FAIL wrap_extra: got rd %0d with nothing outstanding", wb_rd);
                end else begin
                    e = expq.pop_front();
                    if ({wb_pred_miss_, wb_rd, wb_data} !== e) begin
                        n_fail++;
                        $display("FAIL wrap_order_%0d: got %h expected %h", got, {wb_pred_miss_, wb_rd, wb_data}, e);
                    end
                end
                got++;
            end
        end
        idle();
        n_cmp++; if (got !== 3*DEPTH) begin n_fail++; $display("FAIL wrap_count: got %0d writebacks expected %0d", got, 3*DEPTH); end
        n_cmp++; if (expq.size() != 0) begin n_fail++; $display("FAIL wrap_leftover: got %0d expected 0", expq.size()); end
        tick();
        n_cmp++; if (wb_e_ !== 1'b1 || count !== 3'd0) begin n_fail++; $display("FAIL wrap_end: got e %0b count %0d expected 1/0", wb_e_, count); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_fill_drain();
        test_push_pop();
        test_flush();
        test_async_reset();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
